imem_loader: RTL and testbench

Boot-time writer for the instruction memory that the single-cycle CPU fetches from. It accepts a byte stream over a valid/ready handshake, assembles 32-bit instruction words MSB-first, and writes them to consecutive word addresses starting at 0. It holds the CPU stopped (`cpu_run` low) until the full program has been written. It sits between the host/debug byte link and the instruction memory write port, alongside the CPU top.

---
 rtl/loader_pkg.sv | 16 +
 rtl/word_assembler.sv | 34 +++
 rtl/imem_loader.sv | 101 ++++++++++
 tb/tb_imem_loader.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// loader_pkg: shared types and sizes for the instruction-memory boot loader.
package loader_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_WORD,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: shifts bytes MSB-first into a word; word_o/word_full_o reflect the byte being loaded now.
module word_assembler
    import loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_full_o
);
    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;

    always_comb begin
        word_d      = clr_i ? '0 : load_i ? {word_q[WORD_W-9:0], byte_i} : word_q;
        cnt_d       = clr_i ? '0 : load_i ? cnt_q + 1'b1 : cnt_q;
        word_o      = word_d;
        word_full_o = load_i && cnt_q == CNT_W'(BYTES_PER_WORD - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream, writes 32-bit words to instruction memory
// from address 0, and holds the CPU until the whole program is written.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              err
);
    localparam int LEN_W = 8 * LEN_BYTES;
    localparam int CMP_W = LEN_W + 1;

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d, n_w;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d, word_w;
    logic              xfer, load, word_full, last_w, over_w;

    assign xfer   = rx_valid && rx_ready;
    assign load   = xfer && state_q == S_WORD;
    assign n_w    = {len_q[LEN_W-1:8], rx_data};
    // Compare one bit wider so a capacity of exactly 2^ADDR_W words is representable
    assign over_w = CMP_W'(n_w) > (CMP_W'(1) << ADDR_W);
    assign last_w = CMP_W'(word_cnt_q) + CMP_W'(1) == CMP_W'(len_q);

    word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (state_q == S_IDLE),
        .load_i     (load),
        .byte_i     (rx_data),
        .word_o     (word_w),
        .word_full_o(word_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_LEN_HI;
            S_LEN_HI: state_d = xfer ? S_LEN_LO : S_LEN_HI;
            S_LEN_LO: state_d = !xfer ? S_LEN_LO : n_w == '0 ? S_DONE : over_w ? S_ERR : S_WORD;
            S_WORD:   state_d = word_full ? S_WRITE : S_WORD;
            S_WRITE:  state_d = last_w ? S_DONE : S_WORD;
            default:  state_d = state_q;
        endcase
    end

    always_comb begin
        rx_ready = state_q inside {S_LEN_HI, S_LEN_LO, S_WORD};
        busy     = state_q inside {S_LEN_HI, S_LEN_LO, S_WORD, S_WRITE};
        cpu_run  = state_q == S_DONE;
        err      = state_q == S_ERR;
    end

    always_comb begin
        len_d = len_q;
        if (xfer && state_q == S_LEN_HI) len_d[LEN_W-1:8] = rx_data;
        if (xfer && state_q == S_LEN_LO) len_d[7:0] = rx_data;
        word_cnt_d = state_q == S_WRITE ? word_cnt_q + 1'b1 : word_cnt_q;
        we_d       = word_full;
        addr_d     = word_full ? word_cnt_q[ADDR_W-1:0] : addr_q;
        wdata_d    = word_full ? word_w : wdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            word_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of framing, write timing, backpressure, overflow, capacity and reset.
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready, imem_we, cpu_run, busy, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    int n_tests = 0;
    int n_fail = 0;
    int ready_viol = 0;
    logic [ADDR_W+31:0] wlog[$];
    logic [7:0] stream[$];
    logic [7:0] two_word[10] = '{8'h00, 8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h8C, 8'h22, 8'h00, 8'h03};

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .err       (err)
    );

    // Every write strobe is logged; a ready seen alongside it means a byte could land mid-write
    always @(negedge clk) begin
        if (imem_we) begin
            wlog.push_back({imem_addr, imem_wdata});
            if (rx_ready) ready_viol++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        #1;
        wlog.delete();
        ready_viol = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        rx_data = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("rx_wait_timeout", 64'(rx_ready), 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input int gapmax);
        foreach (stream[i]) send_byte(stream[i], int'($urandom_range(gapmax, 0)));
        stream.delete();
    endtask

    task automatic push_two_word();
        foreach (two_word[i]) stream.push_back(two_word[i]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        @(negedge clk);
        check("rst_ctrl", 64'({rx_ready, imem_we, cpu_run, busy, err}), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_wdata", 64'(imem_wdata), 64'd0);
        rst_n = 1'b1;
        #1;
        check("ready_at_release", 64'(rx_ready), 64'd0);
        @(negedge clk);
        check("ready_after_release", 64'(rx_ready), 64'd1);
        check("busy_after_release", 64'(busy), 64'd1);

        // Two-word load, byte offered during WRITE
        push_two_word();
        send_stream(0);
        check("tw_we_last", 64'(imem_we), 64'd1);
        check("tw_run_early", 64'(cpu_run), 64'd0);
        @(negedge clk);
        check("tw_run", 64'(cpu_run), 64'd1);
        check("tw_busy_done", 64'(busy), 64'd0);
        @(negedge clk);
        check("tw_nwrites", 64'(wlog.size()), 64'd2);
        check("tw_w0", 64'(wlog[0]), 64'h00_2001_0005);
        check("tw_w1", 64'(wlog[1]), 64'h01_8C22_0003);
        check("tw_ready_viol", 64'(ready_viol), 64'd0);

        // Empty program
        do_reset();
        stream.push_back(8'h00);
        stream.push_back(8'h00);
        send_stream(0);
        check("empty_run", 64'(cpu_run), 64'd1);
        check("empty_err", 64'(err), 64'd0);
        repeat (3) @(negedge clk);
        check("empty_nwrites", 64'(wlog.size()), 64'd0);

        // Random idle gaps
        do_reset();
        push_two_word();
        send_stream(3);
        repeat (2) @(negedge clk);
        check("gap_nwrites", 64'(wlog.size()), 64'd2);
        check("gap_w0", 64'(wlog[0]), 64'h00_2001_0005);
        check("gap_w1", 64'(wlog[1]), 64'h01_8C22_0003);
        check("gap_ready_viol", 64'(ready_viol), 64'd0);
        check("gap_run", 64'(cpu_run), 64'd1);

        // Overflow: N=257
        do_reset();
        stream.push_back(8'h01);
        stream.push_back(8'h01);
        send_stream(0);
        check("ovf_err", 64'(err), 64'd1);
        check("ovf_ready", 64'(rx_ready), 64'd0);
        check("ovf_run", 64'(cpu_run), 64'd0);
        rx_data = 8'hAA;
        rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        check("ovf_nwrites", 64'(wlog.size()), 64'd0);
        check("ovf_err_sticky", 64'(err), 64'd1);
        check("ovf_run_held", 64'(cpu_run), 64'd0);

        // Full capacity: N=256, word i = i
        do_reset();
        stream.push_back(8'h01);
        stream.push_back(8'h00);
        for (int i = 0; i < 256; i++) begin
            stream.push_back(8'h00);
            stream.push_back(8'h00);
            stream.push_back(8'h00);
            stream.push_back(8'(i));
        end
        send_stream(0);
        repeat (2) @(negedge clk);
        check("full_nwrites", 64'(wlog.size()), 64'd256);
        check("full_first", 64'(wlog[0]), 64'h00_0000_0000);
        check("full_last", 64'(wlog[255]), 64'hFF_0000_00FF);
        bad = 0;
        foreach (wlog[i]) if (wlog[i] !== {8'(i), 32'(i)}) bad++;
        check("full_bad_entries", 64'(bad), 64'd0);
        check("full_run", 64'(cpu_run), 64'd1);
        check("full_err", 64'(err), 64'd0);

        // Reset after 2 bytes of word 1
        do_reset();
        for (int i = 0; i < 8; i++) stream.push_back(two_word[i]);
        send_stream(0);
        check("mid_busy", 64'(busy), 64'd1);
        check("mid_wdata_pre", 64'(imem_wdata), 64'h2001_0005);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", 64'({rx_ready, imem_we, cpu_run, busy, err}), 64'd0);
        check("mid_rst_addr", 64'(imem_addr), 64'd0);
        check("mid_rst_wdata", 64'(imem_wdata), 64'd0);
        wlog.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_ready_release", 64'(rx_ready), 64'd0);
        @(negedge clk);
        check("mid_ready_after", 64'(rx_ready), 64'd1);
        push_two_word();
        send_stream(0);
        repeat (2) @(negedge clk);
        check("mid_nwrites", 64'(wlog.size()), 64'd2);
        check("mid_w0", 64'(wlog[0]), 64'h00_2001_0005);
        check("mid_w1", 64'(wlog[1]), 64'h01_8C22_0003);
        check("mid_run", 64'(cpu_run), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
